// File: rtl/phy_loopback_channel_pkg.sv
// Shared constants and types for the PHY loopback channel model.
package phy_loopback_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        RESET,
        SYNC,
        LOCKED
    } state_e;

    // One ring word: K flag in the MSB, symbol below it.
    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

endpackage

// File: rtl/phy_loopback_channel_if.sv
// TBI symbol bus between the wr_core PHY interface and the loopback channel.
interface phy_loopback_channel_if;

    logic [7:0] tx_data_i;
    logic       tx_k_i;
    logic       phy_rst_i;
    logic       tx_disparity_o;
    logic       tx_enc_err_o;
    logic [7:0] rx_data_o;
    logic       rx_k_o;
    logic       rx_enc_err_o;
    logic [3:0] rx_bitslide_o;

    modport master (
        output tx_data_i, tx_k_i, phy_rst_i,
        input  tx_disparity_o, tx_enc_err_o,
        input  rx_data_o, rx_k_o, rx_enc_err_o, rx_bitslide_o
    );

    modport slave (
        input  tx_data_i, tx_k_i, phy_rst_i,
        output tx_disparity_o, tx_enc_err_o,
        output rx_data_o, rx_k_o, rx_enc_err_o, rx_bitslide_o
    );

endinterface

// File: rtl/phy_loopback_delay_ring.sv
// Circular buffer of symbol+K words with synchronous clear and indexed read.
module phy_loopback_delay_ring
    import phy_loopback_pkg::*;
#(
    parameter int unsigned g_addr_width = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    we_i,
    input  sym_t                    wr_data_i,
    input  logic [g_addr_width-1:0] rd_idx_i,
    output logic [g_addr_width-1:0] wr_ptr_o,
    output sym_t                    rd_data_o
);

    localparam int unsigned DEPTH = 1 << g_addr_width;

    sym_t                    mem_q [DEPTH];
    logic [g_addr_width-1:0] wr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (we_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + g_addr_width'(1);
        end
    end

    // Reading the slot being written returns the incoming word, giving a zero-delay path.
    always_comb begin
        rd_data_o = mem_q[rd_idx_i];
        if (we_i && (rd_idx_i == wr_ptr_q)) begin
            rd_data_o = wr_data_i;
        end
    end

    assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/phy_loopback_channel.sv
// Loopback channel: programmable-latency symbol ring with comma-sync link-up and error injection.
module phy_loopback_channel
    import phy_loopback_pkg::*;
#(
    parameter int unsigned g_delay_width = 4,
    parameter int unsigned g_sync_cycles = 32,
    parameter int unsigned g_bitslide    = 0
) (
    input  logic                     clk_ref_i,
    input  logic                     rst_n_i,
    phy_loopback_channel_if.slave    phy,
    input  logic [g_delay_width-1:0] cfg_delay_i,
    input  logic                     inj_err_i,
    input  logic [15:0]              inj_period_i,
    output logic                     locked_o,
    output logic [15:0]              err_cnt_o
);

    localparam int unsigned SYNC_W = (g_sync_cycles > 1) ? $clog2(g_sync_cycles) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(g_sync_cycles - 1);
    localparam logic [3:0] BITSLIDE = 4'(g_bitslide);

    state_e                   state_q;
    logic [SYNC_W-1:0]        sync_cnt_q;
    logic [g_delay_width-1:0] cfg_delay_q;
    logic [15:0]              per_cnt_q;
    logic [15:0]              err_cnt_q;
    logic                     pend_q;
    logic                     disp_q;
    logic [7:0]               rx_data_q;
    logic                     rx_k_q;
    logic                     rx_err_q;
    logic [3:0]               bitslide_q;
    logic                     locked_q;

    logic [g_delay_width-1:0] wr_ptr;
    logic [g_delay_width-1:0] rd_idx;
    sym_t                     ring_wr;
    sym_t                     ring_rd;
    logic                     is_comma;
    logic                     per_hit;
    logic                     inj_req;
    logic                     cfg_changed;

    assign ring_wr     = '{k: phy.tx_k_i, data: phy.tx_data_i};
    assign rd_idx      = wr_ptr - cfg_delay_i;
    assign is_comma    = phy.tx_k_i && (phy.tx_data_i == K28_5);
    assign per_hit     = (inj_period_i != '0) && (per_cnt_q == inj_period_i - 16'd1);
    assign inj_req     = pend_q || inj_err_i || per_hit;
    assign cfg_changed = (cfg_delay_i != cfg_delay_q);

    phy_loopback_delay_ring #(
        .g_addr_width(g_delay_width)
    ) u_ring (
        .clk_i    (clk_ref_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (state_q == RESET),
        .we_i     (state_q != RESET),
        .wr_data_i(ring_wr),
        .rd_idx_i (rd_idx),
        .wr_ptr_o (wr_ptr),
        .rd_data_o(ring_rd)
    );

    always_ff @(posedge clk_ref_i) begin
        cfg_delay_q <= cfg_delay_i;
        if (!rst_n_i) begin
            state_q    <= RESET;
            sync_cnt_q <= '0;
            cfg_delay_q <= '0;
            per_cnt_q  <= '0;
            err_cnt_q  <= '0;
            pend_q     <= 1'b0;
            disp_q     <= 1'b0;
            rx_data_q  <= K28_5;
            rx_k_q     <= 1'b1;
            rx_err_q   <= 1'b0;
            bitslide_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            rx_err_q <= 1'b0;
            if (phy.phy_rst_i) begin
                // Error count survives a PHY reset; only rst_n_i clears it.
                state_q    <= RESET;
                sync_cnt_q <= '0;
                per_cnt_q  <= '0;
                pend_q     <= 1'b0;
                disp_q     <= 1'b0;
                rx_data_q  <= K28_5;
                rx_k_q     <= 1'b1;
                bitslide_q <= '0;
                locked_q   <= 1'b0;
            end else begin
                if ((state_q != RESET) && is_comma) begin
                    disp_q <= ~disp_q;
                end
                unique case (state_q)
                    RESET: begin
                        state_q    <= SYNC;
                        sync_cnt_q <= '0;
                    end
                    SYNC: begin
                        per_cnt_q <= '0;
                        pend_q    <= 1'b0;
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            bitslide_q <= BITSLIDE;
                            rx_data_q  <= ring_rd.data;
                            rx_k_q     <= ring_rd.k;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + SYNC_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (cfg_changed) begin
                            state_q    <= SYNC;
                            sync_cnt_q <= '0;
                            per_cnt_q  <= '0;
                            pend_q     <= 1'b0;
                            locked_q   <= 1'b0;
                            bitslide_q <= '0;
                            rx_data_q  <= K28_5;
                            rx_k_q     <= 1'b1;
                        end else begin
                            if (inj_period_i == '0 || per_hit) begin
                                per_cnt_q <= '0;
                            end else begin
                                per_cnt_q <= per_cnt_q + 16'd1;
                            end
                            rx_k_q <= ring_rd.k;
                            // A pending request waits across K symbols and fires on the next data symbol.
                            if (inj_req && !ring_rd.k) begin
                                rx_data_q <= ring_rd.data ^ 8'h01;
                                rx_err_q  <= 1'b1;
                                pend_q    <= 1'b0;
                                if (err_cnt_q != 16'hFFFF) begin
                                    err_cnt_q <= err_cnt_q + 16'd1;
                                end
                            end else begin
                                rx_data_q <= ring_rd.data;
                                pend_q    <= inj_req;
                            end
                        end
                    end
                    default: state_q <= RESET;
                endcase
            end
        end
    end

    assign phy.tx_disparity_o = disp_q;
    assign phy.tx_enc_err_o   = 1'b0;
    assign phy.rx_data_o      = rx_data_q;
    assign phy.rx_k_o         = rx_k_q;
    assign phy.rx_enc_err_o   = rx_err_q;
    assign phy.rx_bitslide_o  = bitslide_q;
    assign locked_o           = locked_q;
    assign err_cnt_o          = err_cnt_q;

endmodule

// File: tb/tb_phy_loopback_channel.sv
// Directed self-checking bench for phy_loopback_channel.
module tb_phy_loopback_channel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg;
    logic        inj;
    logic [15:0] period;
    logic        locked;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phy_loopback_channel_if phy_if();

    phy_loopback_channel #(
        .g_delay_width(4),
        .g_sync_cycles(32),
        .g_bitslide   (5)
    ) dut (
        .clk_ref_i   (clk),
        .rst_n_i     (rst_n),
        .phy         (phy_if),
        .cfg_delay_i (cfg),
        .inj_err_i   (inj),
        .inj_period_i(period),
        .locked_o    (locked),
        .err_cnt_o   (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock();
        int n = 0;
        while (locked !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL wait_lock: locked_o=%b required 1 within 100 cycles", locked);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; phy_if.phy_rst_i = 1'b0; phy_if.tx_data_i = 8'h00; phy_if.tx_k_i = 1'b0;
        cfg = 4'd0; inj = 1'b0; period = 16'd0;
        tick(); tick();
        checks += 8;
        if (phy_if.rx_data_o !== 8'hBC) begin errors++; $display("FAIL reset_rx_data: got %h want bc", phy_if.rx_data_o); end
        if (phy_if.rx_k_o !== 1'b1) begin errors++; $display("FAIL reset_rx_k: got %b want 1", phy_if.rx_k_o); end
        if (phy_if.rx_enc_err_o !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %b want 0", phy_if.rx_enc_err_o); end
        if (phy_if.rx_bitslide_o !== 4'd0) begin errors++; $display("FAIL reset_bitslide: got %h want 0", phy_if.rx_bitslide_o); end
        if (phy_if.tx_disparity_o !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b want 0", phy_if.tx_disparity_o); end
        if (phy_if.tx_enc_err_o !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", phy_if.tx_enc_err_o); end
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
    endtask

    task automatic test_lock();
        phy_if.tx_data_i = 8'h55; phy_if.tx_k_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (phy_if.rx_data_o !== 8'hBC || phy_if.rx_k_o !== 1'b1 || locked !== 1'b0) begin
                errors++;
                $display("FAIL sync_comma cycle %0d: got %h/k%b locked %b want bc/k1 locked 0",
                         i, phy_if.rx_data_o, phy_if.rx_k_o, locked);
            end
        end
        tick();
        checks += 3;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_cycle33: locked_o=%b want 1", locked); end
        if (phy_if.rx_bitslide_o !== 4'd5) begin errors++; $display("FAIL lock_bitslide: got %h want 5", phy_if.rx_bitslide_o); end
        if (phy_if.rx_data_o !== 8'h55 || phy_if.rx_k_o !== 1'b0) begin
            errors++; $display("FAIL lock_first_data: got %h/k%b want 55/k0", phy_if.rx_data_o, phy_if.rx_k_o);
        end
        phy_if.tx_data_i = 8'hA3;
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'hA3) begin errors++; $display("FAIL latency1: got %h want a3", phy_if.rx_data_o); end
    endtask

    task automatic test_ramp();
        logic [7:0] exp;
        cfg = 4'd15;
        tick();
        wait_lock();
        for (int i = 0; i < 271; i++) begin
            phy_if.tx_data_i = (i < 256) ? 8'(i) : 8'hEE;
            phy_if.tx_k_i = 1'b0;
            tick();
            if (i >= 15) begin
                exp = 8'(i - 15);
                checks++;
                if (phy_if.rx_data_o !== exp || phy_if.rx_k_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp16 step %0d: got %h/k%b want %h/k0", i, phy_if.rx_data_o, phy_if.rx_k_o, exp);
                end
            end
        end
    endtask

    task automatic test_cfg_change();
        logic [7:0] exp;
        cfg = 4'd3;
        tick();
        wait_lock();
        phy_if.tx_data_i = 8'h77;
        repeat (4) tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h77) begin errors++; $display("FAIL cfg3_data: got %h want 77", phy_if.rx_data_o); end
        cfg = 4'd7;
        tick();
        checks++;
        if (locked !== 1'b0 || phy_if.rx_data_o !== 8'hBC || phy_if.rx_k_o !== 1'b1) begin
            errors++; $display("FAIL cfg_drop: locked %b rx %h/k%b want 0 bc/k1", locked, phy_if.rx_data_o, phy_if.rx_k_o);
        end
        for (int i = 2; i <= 32; i++) begin
            tick();
            checks++;
            if (locked !== 1'b0 || phy_if.rx_data_o !== 8'hBC || phy_if.rx_k_o !== 1'b1) begin
                errors++; $display("FAIL resync_comma %0d: locked %b rx %h/k%b", i, locked, phy_if.rx_data_o, phy_if.rx_k_o);
            end
        end
        tick();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock: locked_o=%b want 1", locked); end
        for (int i = 0; i < 16; i++) begin
            phy_if.tx_data_i = 8'(8'h40 + i);
            tick();
            if (i >= 7) begin
                exp = 8'(8'h40 + i - 7);
                checks++;
                if (phy_if.rx_data_o !== exp) begin
                    errors++; $display("FAIL latency8 step %0d: got %h want %h", i, phy_if.rx_data_o, exp);
                end
            end
        end
    endtask

    task automatic test_inject();
        cfg = 4'd0;
        tick();
        wait_lock();
        phy_if.tx_data_i = 8'h20; phy_if.tx_k_i = 1'b0;
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h20 || phy_if.rx_enc_err_o !== 1'b0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL inj_idle: rx %h err %b cnt %0d want 20 0 0", phy_if.rx_data_o, phy_if.rx_enc_err_o, err_cnt);
        end
        phy_if.tx_data_i = 8'hBC; phy_if.tx_k_i = 1'b1; inj = 1'b1;
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'hBC || phy_if.rx_k_o !== 1'b1 || phy_if.rx_enc_err_o !== 1'b0) begin
            errors++; $display("FAIL inj_k_pass: rx %h/k%b err %b want bc/k1 0", phy_if.rx_data_o, phy_if.rx_k_o, phy_if.rx_enc_err_o);
        end
        inj = 1'b0; phy_if.tx_data_i = 8'h10; phy_if.tx_k_i = 1'b0;
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h11 || phy_if.rx_enc_err_o !== 1'b1 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL inj_hit: rx %h err %b cnt %0d want 11 1 1", phy_if.rx_data_o, phy_if.rx_enc_err_o, err_cnt);
        end
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h10 || phy_if.rx_enc_err_o !== 1'b0 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL inj_once: rx %h err %b cnt %0d want 10 0 1", phy_if.rx_data_o, phy_if.rx_enc_err_o, err_cnt);
        end
        phy_if.tx_data_i = 8'hBC; phy_if.tx_k_i = 1'b1; inj = 1'b1;
        tick(); tick();
        inj = 1'b0; phy_if.tx_data_i = 8'h30; phy_if.tx_k_i = 1'b0;
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h31 || phy_if.rx_enc_err_o !== 1'b1 || err_cnt !== 16'd2) begin
            errors++; $display("FAIL inj_collapse_hit: rx %h err %b cnt %0d want 31 1 2", phy_if.rx_data_o, phy_if.rx_enc_err_o, err_cnt);
        end
        tick();
        checks++;
        if (phy_if.rx_data_o !== 8'h30 || phy_if.rx_enc_err_o !== 1'b0 || err_cnt !== 16'd2) begin
            errors++; $display("FAIL inj_collapse_once: rx %h err %b cnt %0d want 30 0 2", phy_if.rx_data_o, phy_if.rx_enc_err_o, err_cnt);
        end
    endtask

    task automatic test_periodic();
        int pulses = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; phy_if.tx_data_i = 8'h5A; phy_if.tx_k_i = 1'b0;
        tick();
        wait_lock();
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL period_start_cnt: got %0d want 0", err_cnt); end
        period = 16'd100;
        repeat (1000) begin
            tick();
            if (phy_if.rx_enc_err_o === 1'b1) pulses++;
        end
        period = 16'd0;
        checks += 2;
        if (pulses != 10) begin errors++; $display("FAIL period_pulses: got %0d want 10", pulses); end
        if (err_cnt !== 16'd10) begin errors++; $display("FAIL period_cnt: got %0d want 10", err_cnt); end
        phy_if.phy_rst_i = 1'b1;
        tick();
        checks += 2;
        if (phy_if.rx_data_o !== 8'hBC || phy_if.rx_k_o !== 1'b1 || phy_if.rx_enc_err_o !== 1'b0 ||
            phy_if.rx_bitslide_o !== 4'd0 || locked !== 1'b0 || phy_if.tx_disparity_o !== 1'b0) begin
            errors++;
            $display("FAIL phy_rst_outputs: rx %h/k%b err %b slide %h locked %b disp %b",
                     phy_if.rx_data_o, phy_if.rx_k_o, phy_if.rx_enc_err_o, phy_if.rx_bitslide_o, locked, phy_if.tx_disparity_o);
        end
        if (err_cnt !== 16'd10) begin errors++; $display("FAIL phy_rst_cnt: got %0d want 10", err_cnt); end
        repeat (5) tick();
        checks++;
        if (err_cnt !== 16'd10 || locked !== 1'b0) begin
            errors++; $display("FAIL phy_rst_hold: cnt %0d locked %b want 10 0", err_cnt, locked);
        end
        phy_if.phy_rst_i = 1'b0; rst_n = 1'b0;
        tick();
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_n_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_disparity();
        logic exp = 1'b0;
        rst_n = 1'b1; phy_if.tx_data_i = 8'hBC; phy_if.tx_k_i = 1'b1;
        tick();
        checks++;
        if (phy_if.tx_disparity_o !== 1'b0) begin errors++; $display("FAIL disp_in_reset: got %b want 0", phy_if.tx_disparity_o); end
        phy_if.tx_k_i = 1'b0;
        tick();
        checks++;
        if (phy_if.tx_disparity_o !== 1'b0) begin errors++; $display("FAIL disp_bc_not_k: got %b want 0", phy_if.tx_disparity_o); end
        for (int i = 0; i < 7; i++) begin
            phy_if.tx_data_i = 8'hBC; phy_if.tx_k_i = 1'b1;
            tick();
            exp = ~exp;
            checks++;
            if (phy_if.tx_disparity_o !== exp) begin errors++; $display("FAIL disp_comma %0d: got %b want %b", i, phy_if.tx_disparity_o, exp); end
            phy_if.tx_data_i = 8'h00; phy_if.tx_k_i = 1'b0;
            tick();
            checks++;
            if (phy_if.tx_disparity_o !== exp) begin errors++; $display("FAIL disp_data %0d: got %b want %b", i, phy_if.tx_disparity_o, exp); end
        end
        phy_if.tx_data_i = 8'hBC; phy_if.tx_k_i = 1'b1; rst_n = 1'b0;
        tick();
        checks++;
        if (phy_if.tx_disparity_o !== 1'b0) begin errors++; $display("FAIL disp_rst: got %b want 0", phy_if.tx_disparity_o); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_ramp();
        test_cfg_change();
        test_inject();
        test_periodic();
        test_disparity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
